// File: rtl/hack_ps2_keyboard.sv
// PS/2 keyboard receiver and Hack key-code decoder.
// Deserialises 11-bit PS/2 frames (start, 8 data LSB first, odd parity,
// stop), tracks scan-code set 2 make/break/extended prefixes and holds the
// Hack code of the currently pressed key (0 when none) for the 0x6000
// keyboard register.
//
// Handshake: the receiver has no back-pressure. scan_valid is a one-cycle
// strobe qualifying scan_code; frame_err is a one-cycle strobe for a dropped
// frame; the two are never high together. key_code is a level that changes
// one cycle after the scan_valid strobe that caused it.
module hack_ps2_keyboard #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [WIDTH-1:0] key_code,
    output logic             scan_valid,
    output logic [7:0]       scan_code,
    output logic             frame_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic         r_clk_meta, r_clk_sync, r_clk_prev;
    logic         r_dat_meta, r_dat_sync;
    logic         w_fall;
    state_t       r_state, w_state_nxt;
    logic [3:0]   r_bitcnt;
    logic [8:0]   r_shreg;
    logic [TW-1:0] r_to_cnt;
    logic         w_start, w_shift, w_good, w_bad, w_timeout, w_to_hit;
    logic         r_brk, r_ext;
    logic [8:0]   w_map;

    // Two-flop synchronisers for the asynchronous PS/2 lines, idle-high preset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync;
    // The counter lands on TIMEOUT_CYCLES-1 in the same cycle frame_err rises.
    assign w_to_hit  = (r_to_cnt == TW'(TIMEOUT_CYCLES - 2));
    assign dbg_state = r_state;

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Frame FSM next-state and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A fall with data high is line noise, not a start bit.
                if (w_fall && !r_dat_sync) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_fall) begin
                    w_shift = 1'b1;
                    if (r_bitcnt == 4'd8) w_state_nxt = ST_STOP;
                end else if (w_to_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    if (r_dat_sync && (^r_shreg)) w_good = 1'b1;
                    else                          w_bad  = 1'b1;
                end else if (w_to_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift register and bit counter for data+parity
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bitcnt <= 4'd0;
            r_shreg  <= 9'd0;
        end else if (w_start) begin
            r_bitcnt <= 4'd0;
            r_shreg  <= 9'd0;
        end else if (w_shift) begin
            r_bitcnt <= r_bitcnt + 4'd1;
            r_shreg  <= {r_dat_sync, r_shreg[8:1]};
        end
    end

    // Mid-frame watchdog: cleared on every fall, idle outside a frame
    always_ff @(posedge clk) begin
        if (!reset || w_fall || r_state == ST_IDLE) r_to_cnt <= '0;
        else                                        r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Registered receiver strobes and last good byte
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_valid <= 1'b0;
            scan_code  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= w_good;
            frame_err  <= w_bad | w_timeout;
            if (w_good) scan_code <= r_shreg[7:0];
        end
    end

    // Set-2 scan code to Hack code; bit 8 flags a mapped key
    function automatic logic [8:0] map_key(input logic ext, input logic [7:0] sc);
        logic [8:0] r;
        r = 9'd0;
        if (!ext) begin
            case (sc)
                8'h1C: r = {1'b1, 8'd65};  8'h32: r = {1'b1, 8'd66};
                8'h21: r = {1'b1, 8'd67};  8'h23: r = {1'b1, 8'd68};
                8'h24: r = {1'b1, 8'd69};  8'h2B: r = {1'b1, 8'd70};
                8'h34: r = {1'b1, 8'd71};  8'h33: r = {1'b1, 8'd72};
                8'h43: r = {1'b1, 8'd73};  8'h3B: r = {1'b1, 8'd74};
                8'h42: r = {1'b1, 8'd75};  8'h4B: r = {1'b1, 8'd76};
                8'h3A: r = {1'b1, 8'd77};  8'h31: r = {1'b1, 8'd78};
                8'h44: r = {1'b1, 8'd79};  8'h4D: r = {1'b1, 8'd80};
                8'h15: r = {1'b1, 8'd81};  8'h2D: r = {1'b1, 8'd82};
                8'h1B: r = {1'b1, 8'd83};  8'h2C: r = {1'b1, 8'd84};
                8'h3C: r = {1'b1, 8'd85};  8'h2A: r = {1'b1, 8'd86};
                8'h1D: r = {1'b1, 8'd87};  8'h22: r = {1'b1, 8'd88};
                8'h35: r = {1'b1, 8'd89};  8'h1A: r = {1'b1, 8'd90};
                8'h45: r = {1'b1, 8'd48};  8'h16: r = {1'b1, 8'd49};
                8'h1E: r = {1'b1, 8'd50};  8'h26: r = {1'b1, 8'd51};
                8'h25: r = {1'b1, 8'd52};  8'h2E: r = {1'b1, 8'd53};
                8'h36: r = {1'b1, 8'd54};  8'h3D: r = {1'b1, 8'd55};
                8'h3E: r = {1'b1, 8'd56};  8'h46: r = {1'b1, 8'd57};
                8'h29: r = {1'b1, 8'd32};  8'h5A: r = {1'b1, 8'd128};
                8'h66: r = {1'b1, 8'd129}; 8'h76: r = {1'b1, 8'd140};
                8'h05: r = {1'b1, 8'd141}; 8'h06: r = {1'b1, 8'd142};
                8'h04: r = {1'b1, 8'd143}; 8'h0C: r = {1'b1, 8'd144};
                8'h03: r = {1'b1, 8'd145}; 8'h0B: r = {1'b1, 8'd146};
                8'h83: r = {1'b1, 8'd147}; 8'h0A: r = {1'b1, 8'd148};
                8'h01: r = {1'b1, 8'd149}; 8'h09: r = {1'b1, 8'd150};
                8'h78: r = {1'b1, 8'd151}; 8'h07: r = {1'b1, 8'd152};
                default: r = 9'd0;
            endcase
        end else begin
            case (sc)
                8'h6B: r = {1'b1, 8'd130}; 8'h75: r = {1'b1, 8'd131};
                8'h74: r = {1'b1, 8'd132}; 8'h72: r = {1'b1, 8'd133};
                8'h6C: r = {1'b1, 8'd134}; 8'h69: r = {1'b1, 8'd135};
                8'h7D: r = {1'b1, 8'd136}; 8'h7A: r = {1'b1, 8'd137};
                8'h70: r = {1'b1, 8'd138}; 8'h71: r = {1'b1, 8'd139};
                default: r = 9'd0;
            endcase
        end
        return r;
    endfunction

    assign w_map = map_key(r_ext, scan_code);

    // Make/break/extended decoder driving the held key code
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_code <= '0;
            r_brk    <= 1'b0;
            r_ext    <= 1'b0;
        end else if (frame_err) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else if (scan_valid) begin
            if (scan_code == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (scan_code == 8'hE0) begin
                r_ext <= 1'b1;
            end else begin
                if (w_map[8]) begin
                    if (!r_brk)                               key_code <= WIDTH'(w_map[7:0]);
                    else if (key_code == WIDTH'(w_map[7:0]))  key_code <= '0;
                end
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hack_ps2_keyboard.sv
// Self-checking bench for hack_ps2_keyboard: directed scenarios plus a
// randomized keystroke stream checked against a table-driven key model.
module tb_hack_ps2_keyboard;

  localparam int WIDTH = 16;
  localparam int TO    = 400;
  localparam int HALF  = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ps2_clk = 1'b1;
  logic             ps2_data = 1'b1;
  logic [WIDTH-1:0] key_code;
  logic             scan_valid;
  logic [7:0]       scan_code;
  logic             frame_err;
  logic [1:0]       dbg_state;

  int checks = 0;
  int failures = 0;

  // key model
  int map_ne[int];
  int map_ex[int];
  int keys_ne[$];
  int keys_ex[$];
  int m_key;
  bit m_brk, m_ext;

  // observations from the last frame's stop-bit window
  int         o_nv, o_ne, o_sv_k, o_err_k;
  logic [7:0] o_code;
  logic [WIDTH-1:0] o_key_pre, o_key_post;
  bit         o_both;

  always #5 clk = ~clk;

  hack_ps2_keyboard #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .scan_valid(scan_valid), .scan_code(scan_code),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic init_maps();
    logic [7:0] letters [26];
    logic [7:0] digits [10];
    logic [7:0] fkeys [12];
    logic [7:0] exts [10];
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    fkeys   = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
    exts    = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
    for (int i = 0; i < 26; i++) map_ne[int'(letters[i])] = 65 + i;
    for (int i = 0; i < 10; i++) map_ne[int'(digits[i])] = 48 + i;
    for (int i = 0; i < 12; i++) map_ne[int'(fkeys[i])] = 141 + i;
    map_ne[32'h29] = 32;
    map_ne[32'h5A] = 128;
    map_ne[32'h66] = 129;
    map_ne[32'h76] = 140;
    for (int i = 0; i < 10; i++) map_ex[int'(exts[i])] = 130 + i;
    foreach (map_ne[k]) keys_ne.push_back(k);
    foreach (map_ex[k]) keys_ex.push_back(k);
  endtask

  function automatic void model_good(input logic [7:0] b);
    bit hit;
    int code;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      hit  = m_ext ? map_ex.exists(int'(b)) : map_ne.exists(int'(b));
      code = 0;
      if (hit) code = m_ext ? map_ex[int'(b)] : map_ne[int'(b)];
      if (hit) begin
        if (!m_brk) m_key = code;
        else if (code == m_key) m_key = 0;
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endfunction

  function automatic void model_err();
    m_brk = 1'b0;
    m_ext = 1'b0;
  endfunction

  function automatic void model_reset();
    m_key = 0;
    m_brk = 1'b0;
    m_ext = 1'b0;
  endfunction

  // one PS/2 bit: data set while clock high, then a full low/high clock period
  task automatic pulse_bit(input logic v);
    @(negedge clk);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // full frame; records strobes during the 8 cycles after the stop-bit fall
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) pulse_bit(fr[i]);
    @(negedge clk);
    ps2_data = fr[10];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    o_nv = 0; o_ne = 0; o_sv_k = 0; o_err_k = 0; o_code = 8'h00; o_both = 1'b0;
    o_key_pre = '0; o_key_post = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (scan_valid === 1'b1) begin
        o_nv++;
        if (o_sv_k == 0) begin o_sv_k = k; o_code = scan_code; end
      end
      if (frame_err === 1'b1) begin
        o_ne++;
        if (o_err_k == 0) o_err_k = k;
      end
      if (scan_valid === 1'b1 && frame_err === 1'b1) o_both = 1'b1;
      if (k == 3) o_key_pre = key_code;
      if (k == 4) o_key_post = key_code;
    end
    repeat (HALF - 8) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (key_code !== '0) begin failures++; $display("FAIL reset_key: got %0d exp 0", key_code); end
    checks++;
    if (scan_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", scan_valid); end
    checks++;
    if (scan_code !== 8'h00) begin failures++; $display("FAIL reset_code: got %h exp 00", scan_code); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", frame_err); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_make();
    send_frame(8'h1C, 1'b0, 1'b0);
    model_good(8'h1C);
    checks++;
    if (!(o_nv == 1 && o_ne == 0 && o_sv_k == 3 && o_code == 8'h1C)) begin
      failures++;
      $display("FAIL make_pulse: got nv=%0d ne=%0d at=%0d code=%h exp nv=1 ne=0 at=3 code=1c", o_nv, o_ne, o_sv_k, o_code);
    end
    checks++;
    if (o_key_pre !== 16'd0 || o_key_post !== 16'd65) begin
      failures++;
      $display("FAIL make_latency: got pre=%0d post=%0d exp pre=0 post=65", o_key_pre, o_key_post);
    end
  endtask

  task automatic test_break();
    logic [7:0] seq [2];
    int prev;
    seq = '{8'hF0, 8'h1C};
    for (int i = 0; i < 2; i++) begin
      prev = m_key;
      send_frame(seq[i], 1'b0, 1'b0);
      model_good(seq[i]);
      checks++;
      if (!(o_nv == 1 && o_ne == 0 && o_sv_k == 3 && o_code == seq[i])) begin
        failures++;
        $display("FAIL break_pulse: got nv=%0d at=%0d code=%h exp nv=1 at=3 code=%h", o_nv, o_sv_k, o_code, seq[i]);
      end
      checks++;
      if (o_key_pre !== WIDTH'(prev) || o_key_post !== WIDTH'(m_key)) begin
        failures++;
        $display("FAIL break_key: got pre=%0d post=%0d exp pre=%0d post=%0d", o_key_pre, o_key_post, prev, m_key);
      end
    end
    checks++;
    if (key_code !== 16'd0) begin failures++; $display("FAIL break_final: got %0d exp 0", key_code); end
  endtask

  task automatic test_ext();
    logic [7:0] seq [10];
    int         want [10];
    seq  = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h1C, 8'h75, 8'h74, 8'hF0, 8'h1C};
    want = '{0, 131, 131, 131, 0, 65, 65, 65, 65, 0};
    for (int i = 0; i < 10; i++) begin
      send_frame(seq[i], 1'b0, 1'b0);
      model_good(seq[i]);
      checks++;
      if (!(o_nv == 1 && o_ne == 0 && o_code == seq[i]) || o_key_post !== WIDTH'(m_key)) begin
        failures++;
        $display("FAIL ext_seq[%0d]: got nv=%0d code=%h key=%0d exp nv=1 code=%h key=%0d", i, o_nv, o_code, o_key_post, seq[i], m_key);
      end
      checks++;
      if (key_code !== WIDTH'(want[i])) begin
        failures++;
        $display("FAIL ext_spec[%0d]: got %0d exp %0d", i, key_code, want[i]);
      end
    end
  endtask

  task automatic test_two_keys();
    logic [7:0] seq [6];
    int         want [6];
    seq  = '{8'h1C, 8'h32, 8'hF0, 8'h1C, 8'hF0, 8'h32};
    want = '{65, 66, 66, 66, 66, 0};
    for (int i = 0; i < 6; i++) begin
      send_frame(seq[i], 1'b0, 1'b0);
      model_good(seq[i]);
      checks++;
      if (o_key_post !== WIDTH'(m_key) || key_code !== WIDTH'(want[i])) begin
        failures++;
        $display("FAIL two_keys[%0d]: got %0d exp model=%0d spec=%0d", i, key_code, m_key, want[i]);
      end
    end
  endtask

  task automatic test_frame_errors();
    // bad parity while key held: error strobe only, key kept
    send_frame(8'h1C, 1'b0, 1'b0);
    model_good(8'h1C);
    send_frame(8'h1C, 1'b1, 1'b0);
    model_err();
    checks++;
    if (!(o_ne == 1 && o_nv == 0 && o_err_k == 3 && !o_both)) begin
      failures++;
      $display("FAIL parity_err: got ne=%0d nv=%0d at=%0d exp ne=1 nv=0 at=3", o_ne, o_nv, o_err_k);
    end
    checks++;
    if (key_code !== 16'd65) begin failures++; $display("FAIL parity_key: got %0d exp 65", key_code); end
    // F0 then a bad stop bit: the error drops the pending break, so 0x32 is a make
    send_frame(8'hF0, 1'b0, 1'b0);
    model_good(8'hF0);
    send_frame(8'h32, 1'b0, 1'b1);
    model_err();
    checks++;
    if (!(o_ne == 1 && o_nv == 0 && o_err_k == 3)) begin
      failures++;
      $display("FAIL stop_err: got ne=%0d nv=%0d at=%0d exp ne=1 nv=0 at=3", o_ne, o_nv, o_err_k);
    end
    send_frame(8'h32, 1'b0, 1'b0);
    model_good(8'h32);
    checks++;
    if (key_code !== 16'd66 || key_code !== WIDTH'(m_key)) begin
      failures++;
      $display("FAIL after_err_key: got %0d exp 66", key_code);
    end
    send_frame(8'hF0, 1'b0, 1'b0);
    model_good(8'hF0);
    send_frame(8'h32, 1'b0, 1'b0);
    model_good(8'h32);
  endtask

  task automatic test_idle_noise();
    int seen;
    seen = 0;
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (int k = 0; k < 2 * HALF; k++) begin
      @(negedge clk);
      if (k == HALF) ps2_clk = 1'b1;
      if (scan_valid !== 1'b0 || frame_err !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL idle_noise: got %0d strobe cycles exp 0", seen); end
    send_frame(8'h21, 1'b0, 1'b0);
    model_good(8'h21);
    checks++;
    if (!(o_nv == 1 && o_code == 8'h21) || key_code !== 16'd67) begin
      failures++;
      $display("FAIL idle_then_frame: got code=%h key=%0d exp code=21 key=67", o_code, key_code);
    end
  endtask

  task automatic test_timeout();
    int err_k, nv;
    logic [4:0] bits;
    bits = 5'b0_1010;
    for (int i = 0; i < 4; i++) pulse_bit(bits[i]);
    @(negedge clk);
    ps2_data = bits[4];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    err_k = 0;
    nv = 0;
    for (int k = 1; k <= TO + 50 && err_k == 0; k++) begin
      @(negedge clk);
      if (k == HALF) begin ps2_clk = 1'b1; ps2_data = 1'b1; end
      if (scan_valid === 1'b1) nv++;
      if (frame_err === 1'b1) err_k = k;
    end
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    model_err();
    checks++;
    if (err_k != TO + 2 || nv != 0) begin
      failures++;
      $display("FAIL timeout: got err at %0d valid=%0d exp err at %0d valid=0", err_k, nv, TO + 2);
    end
    checks++;
    if (key_code !== WIDTH'(m_key)) begin failures++; $display("FAIL timeout_key: got %0d exp %0d", key_code, m_key); end
    repeat (5) @(negedge clk);
    send_frame(8'h32, 1'b0, 1'b0);
    model_good(8'h32);
    checks++;
    if (!(o_nv == 1 && o_ne == 0 && o_code == 8'h32) || key_code !== 16'd66) begin
      failures++;
      $display("FAIL after_timeout: got nv=%0d code=%h key=%0d exp nv=1 code=32 key=66", o_nv, o_code, key_code);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] bits;
    bits = 4'b1100;
    for (int i = 0; i < 4; i++) pulse_bit(bits[i]);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    checks++;
    if (key_code !== '0 || scan_valid !== 1'b0 || scan_code !== 8'h00 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got key=%0d valid=%b code=%h err=%b exp all 0", key_code, scan_valid, scan_code, frame_err);
    end
    reset = 1'b1;
    repeat (HALF) @(negedge clk);
    send_frame(8'h32, 1'b0, 1'b0);
    model_good(8'h32);
    checks++;
    if (!(o_nv == 1 && o_ne == 0 && o_code == 8'h32) || key_code !== 16'd66) begin
      failures++;
      $display("FAIL after_reset: got nv=%0d code=%h key=%0d exp nv=1 code=32 key=66", o_nv, o_code, key_code);
    end
  endtask

  task automatic test_random();
    logic [7:0] fq[$];
    int act, sc, prev;
    bit bp, bs, found;
    for (int it = 0; it < 45; it++) begin
      fq.delete();
      bp = 1'b0;
      bs = 1'b0;
      act = $urandom_range(0, 9);
      case (act)
        0: begin bp = 1'b1; fq.push_back(8'($urandom_range(0, 255))); end
        1: begin bs = 1'b1; fq.push_back(8'($urandom_range(0, 255))); end
        2: fq.push_back(8'($urandom_range(0, 255)));
        3, 4, 5: fq.push_back(8'(keys_ne[$urandom_range(0, keys_ne.size() - 1)]));
        6: begin fq.push_back(8'hE0); fq.push_back(8'(keys_ex[$urandom_range(0, keys_ex.size() - 1)])); end
        default: begin
          found = 1'b0;
          sc = 0;
          foreach (map_ne[k]) if (map_ne[k] == m_key && m_key != 0) begin sc = k; found = 1'b1; end
          if (found) begin
            fq.push_back(8'hF0); fq.push_back(8'(sc));
          end else begin
            foreach (map_ex[k]) if (map_ex[k] == m_key) begin sc = k; found = 1'b1; end
            if (found) begin fq.push_back(8'hE0); fq.push_back(8'hF0); fq.push_back(8'(sc)); end
            else fq.push_back(8'(keys_ne[$urandom_range(0, keys_ne.size() - 1)]));
          end
        end
      endcase
      foreach (fq[j]) begin
        prev = m_key;
        send_frame(fq[j], bp, bs);
        if (bp || bs) begin
          model_err();
          checks++;
          if (!(o_ne == 1 && o_nv == 0 && o_err_k == 3 && !o_both)) begin
            failures++;
            $display("FAIL rnd_err[%0d]: got ne=%0d nv=%0d at=%0d exp ne=1 nv=0 at=3", it, o_ne, o_nv, o_err_k);
          end
        end else begin
          model_good(fq[j]);
          checks++;
          if (!(o_nv == 1 && o_ne == 0 && o_sv_k == 3 && o_code == fq[j] && !o_both)) begin
            failures++;
            $display("FAIL rnd_pulse[%0d]: got nv=%0d ne=%0d at=%0d code=%h exp nv=1 ne=0 at=3 code=%h", it, o_nv, o_ne, o_sv_k, o_code, fq[j]);
          end
        end
        checks++;
        if (o_key_pre !== WIDTH'(prev) || o_key_post !== WIDTH'(m_key)) begin
          failures++;
          $display("FAIL rnd_key[%0d]: byte=%h got pre=%0d post=%0d exp pre=%0d post=%0d", it, fq[j], o_key_pre, o_key_post, prev, m_key);
        end
      end
    end
  endtask

  initial begin
    init_maps();
    test_reset();
    test_make();
    test_break();
    test_ext();
    test_two_keys();
    test_frame_errors();
    test_idle_noise();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
